softmax_seq_ctrl: RTL

SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

---
 rtl/softmax_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl: three-pass sequencer for a streaming softmax.
//   MAX  pass: reads the range and tracks the signed maximum of all lanes.
//   SUM  pass: reads the range again and accumulates the external exp results
//              (saturating, with a sticky flag).
//   NORM pass: reads the range a third time while the external logsub/exp path
//              produces normalised data; out_valid marks when that data is ready.
// Optional feature: define SOFTMAX_SEQ_ABORT_EN to add an 'abort' input that
// cancels a run in progress without producing a done pulse.
module softmax_seq_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int ADDRSIZE  = 8,
    parameter int LAT_EXP   = 3,
    parameter int LAT_OUT   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRSIZE-1:0]      start_addr,
    input  logic [ADDRSIZE-1:0]      end_addr,
`ifdef SOFTMAX_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     rd_en,
    output logic [ADDRSIZE-1:0]      rd_addr,
    input  logic [DATAWIDTH*NUM-1:0] inp,
    input  logic [DATAWIDTH*NUM-1:0] exp_in,
    output logic [1:0]               pass,
    output logic [DATAWIDTH-1:0]     max_out,
    output logic [DATAWIDTH-1:0]     sum_out,
    output logic                     sat,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // Accumulator is wide enough to hold the old sum plus NUM full lanes.
    localparam int SW   = DATAWIDTH + $clog2(NUM) + 1;
    localparam int LMAX = (LAT_EXP > LAT_OUT) ? LAT_EXP : LAT_OUT;
    localparam int CW   = $clog2(LMAX + 2);

    localparam logic [ADDRSIZE-1:0]  A_ONE    = 1;
    localparam logic [CW-1:0]        C_ONE    = 1;
    localparam logic [CW-1:0]        C_EXP    = CW'(LAT_EXP);
    localparam logic [CW-1:0]        C_OUT    = CW'(LAT_OUT);
    localparam logic [DATAWIDTH-1:0] MOST_NEG = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] ALL_ONES = {DATAWIDTH{1'b1}};
    localparam logic [SW-1:0]        SAT_LIM  = {{(SW-DATAWIDTH){1'b0}}, ALL_ONES};

    typedef enum logic [2:0] {
        S_IDLE, S_MAX, S_MWAIT, S_SUM, S_DRAIN, S_NORM, S_FLUSH, S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDRSIZE-1:0]   r_addr;
    logic [ADDRSIZE-1:0]   r_start;
    logic [ADDRSIZE-1:0]   r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_rd_en;
    logic [1:0]            r_pass;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [DATAWIDTH-1:0]  r_max;
    logic [DATAWIDTH-1:0]  r_sum;
    logic                  r_sat;

    logic                  r_max_vld;
    logic [LAT_EXP:0]      r_exp_dl;
    logic [LAT_OUT:0]      r_out_dl;

    logic                  w_abort;
    logic                  w_start_ok;
    logic [DATAWIDTH-1:0]  w_in_lane  [NUM];
    logic [DATAWIDTH-1:0]  w_exp_lane [NUM];
    logic [DATAWIDTH-1:0]  w_max_next;
    logic [SW-1:0]         w_sum_wide;

`ifdef SOFTMAX_SEQ_ABORT_EN
    assign w_abort = abort && r_busy;
`else
    assign w_abort = 1'b0;
`endif

    // An empty or inverted range is rejected without entering the run.
    assign w_start_ok = (r_state == S_IDLE) && start && (start_addr < end_addr);

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_lane
            assign w_in_lane[gi]  = inp[gi*DATAWIDTH +: DATAWIDTH];
            assign w_exp_lane[gi] = exp_in[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    // Lane reduction: signed max against the running max, and the wide exp sum.
    always_comb begin
        w_max_next = r_max;
        w_sum_wide = SW'(r_sum);
        for (int i = 0; i < NUM; i++) begin
            if ($signed(w_in_lane[i]) > $signed(w_max_next))
                w_max_next = w_in_lane[i];
            w_sum_wide = w_sum_wide + SW'(w_exp_lane[i]);
        end
    end

    // Sequencer: walks the three read passes and the fixed wait/drain/flush gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_start <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_rd_en <= 1'b0;
            r_pass  <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_rd_en <= 1'b0;
                r_pass  <= 2'd0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_start <= start_addr;
                            r_last  <= end_addr - A_ONE;
                            r_addr  <= start_addr;
                            r_rd_en <= 1'b1;
                            r_pass  <= 2'd1;
                            r_busy  <= 1'b1;
                            r_state <= S_MAX;
                        end else if (start) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                    S_MAX: begin
                        if (r_addr == r_last) begin
                            r_rd_en <= 1'b0;
                            r_pass  <= 2'd0;
                            r_state <= S_MWAIT;
                        end else begin
                            r_addr <= r_addr + A_ONE;
                        end
                    end
                    S_MWAIT: begin
                        r_addr  <= r_start;
                        r_rd_en <= 1'b1;
                        r_pass  <= 2'd2;
                        r_state <= S_SUM;
                    end
                    S_SUM: begin
                        if (r_addr == r_last) begin
                            r_rd_en <= 1'b0;
                            r_pass  <= 2'd0;
                            r_cnt   <= C_EXP;
                            r_state <= S_DRAIN;
                        end else begin
                            r_addr <= r_addr + A_ONE;
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == '0) begin
                            r_addr  <= r_start;
                            r_rd_en <= 1'b1;
                            r_pass  <= 2'd3;
                            r_state <= S_NORM;
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_NORM: begin
                        if (r_addr == r_last) begin
                            r_rd_en <= 1'b0;
                            r_pass  <= 2'd0;
                            r_cnt   <= C_OUT;
                            r_state <= S_FLUSH;
                        end else begin
                            r_addr <= r_addr + A_ONE;
                        end
                    end
                    S_FLUSH: begin
                        if (r_cnt == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Valid markers: MAX data one cycle after the read, exp data 1+LAT_EXP after a
    // SUM read, normalised data 1+LAT_OUT after a NORM read.
    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_max_vld <= 1'b0;
            r_exp_dl  <= '0;
            r_out_dl  <= '0;
        end else begin
            r_max_vld   <= r_rd_en && (r_state == S_MAX);
            r_exp_dl[0] <= r_rd_en && (r_state == S_SUM);
            r_out_dl[0] <= r_rd_en && (r_state == S_NORM);
            for (int i = LAT_EXP; i > 0; i--) r_exp_dl[i] <= r_exp_dl[i-1];
            for (int i = LAT_OUT; i > 0; i--) r_out_dl[i] <= r_out_dl[i-1];
        end
    end

    // Running max and saturating exp sum; values persist after the run ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max <= '0;
            r_sum <= '0;
            r_sat <= 1'b0;
        end else if (w_start_ok && !w_abort) begin
            r_max <= MOST_NEG;
            r_sum <= '0;
            r_sat <= 1'b0;
        end else if (!w_abort) begin
            if (r_max_vld)
                r_max <= w_max_next;
            if (r_exp_dl[LAT_EXP]) begin
                if (w_sum_wide > SAT_LIM) begin
                    r_sum <= ALL_ONES;
                    r_sat <= 1'b1;
                end else begin
                    r_sum <= w_sum_wide[DATAWIDTH-1:0];
                end
            end
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_addr;
    assign pass      = r_pass;
    assign max_out   = r_max;
    assign sum_out   = r_sum;
    assign sat       = r_sat;
    assign out_valid = r_out_dl[LAT_OUT];
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
